// File: rtl/event_trigger_map_if.sv
// event_trigger_map_if: event-code stream and mapping-table configuration bus
interface event_trigger_map_if #(parameter int NUM_PULSE = 4);
  logic [7:0] event_code;
  logic event_valid;
  logic cfg_we;
  logic [7:0] cfg_addr;
  logic [NUM_PULSE-1:0] cfg_wdata;
  logic [NUM_PULSE-1:0] cfg_rdata;
  modport master (output event_code, event_valid, cfg_we, cfg_addr, cfg_wdata, input cfg_rdata);
  modport slave (input event_code, event_valid, cfg_we, cfg_addr, cfg_wdata, output cfg_rdata);
endinterface

// File: rtl/event_trigger_map.sv
// event_trigger_map: maps event codes to per-channel start strobes with retrigger holdoff
module event_trigger_map #(
  parameter int NUM_PULSE = 4,
  parameter int HOLD_W = 16
) (
  input logic clk,
  input logic reset,
  input logic enable,
  event_trigger_map_if.slave bus,
  input logic [NUM_PULSE*HOLD_W-1:0] holdoff,
  input logic clear_stats,
  output logic [NUM_PULSE-1:0] start,
  output logic [NUM_PULSE-1:0] missed,
  output logic [31:0] trig_count
);
  logic [NUM_PULSE-1:0] tbl [256];
  logic s1_valid;
  logic [7:0] s1_code;
  logic [NUM_PULSE-1:0] s1_row;
  logic [HOLD_W-1:0] cnt [NUM_PULSE];
  logic [NUM_PULSE-1:0] hit, ready, fire;
  // Mapping table with registered readback; reads see the entry before any same-edge write
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int a = 0; a < 256; a++) tbl[a] <= '0;
      bus.cfg_rdata <= '0;
    end else begin
      bus.cfg_rdata <= tbl[bus.cfg_addr];
      if (bus.cfg_we) tbl[bus.cfg_addr] <= bus.cfg_wdata;
    end
  // Stage 1: capture the event and its table row, so a write in the event's cycle is not seen
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_code <= '0;
      s1_row <= '0;
    end else begin
      s1_valid <= bus.event_valid;
      s1_code <= bus.event_code;
      s1_row <= tbl[bus.event_code];
    end
  // Stage 2 qualification: null code and disabled enable never hit; a hit fires only on idle channels
  always_comb begin
    ready = '0;
    hit = (s1_valid && s1_code != 8'h00 && enable) ? s1_row : '0;
    for (int i = 0; i < NUM_PULSE; i++) ready[i] = cnt[i] == '0;
    fire = hit & ready;
  end
  // Holdoff counters: load on fire, otherwise count down to zero and stop
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < NUM_PULSE; i++) cnt[i] <= '0;
    else for (int i = 0; i < NUM_PULSE; i++)
      cnt[i] <= fire[i] ? holdoff[i*HOLD_W +: HOLD_W] : cnt[i] - HOLD_W'(!ready[i]);
  // Strobes and statistics; a new miss or count wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      start <= '0;
      missed <= '0;
      trig_count <= '0;
    end else begin
      start <= fire;
      missed <= (clear_stats ? '0 : missed) | (hit & ~ready);
      trig_count <= clear_stats ? 32'(|start) : trig_count + 32'(|start && trig_count != '1);
    end
endmodule

// File: tb/tb_event_trigger_map.sv
// tb_event_trigger_map: randomized and directed checks against a timestamp-based reference model
module tb_event_trigger_map;
  localparam int NP = 4;
  localparam int HW = 16;
  logic clk = 0;
  logic reset = 1;
  logic enable = 0;
  logic clear_stats = 0;
  logic [NP*HW-1:0] holdoff = '0;
  logic [NP-1:0] start, missed;
  logic [31:0] trig_count;
  int errors = 0;
  int checks = 0;
  bit run = 0;
  bit do_preset = 0;
  logic [NP-1:0] m_tbl [256];
  logic m_v;
  logic [7:0] m_code;
  logic [NP-1:0] m_row;
  longint m_cyc = 0;
  longint m_last [NP];
  logic [HW-1:0] m_hold [NP];
  logic [NP-1:0] e_start, e_missed, e_rdata;
  logic [31:0] e_cnt;
  logic [15:0] s;
  event_trigger_map_if #(.NUM_PULSE(NP)) bus ();
  event_trigger_map #(.NUM_PULSE(NP), .HOLD_W(HW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus), .holdoff(holdoff),
    .clear_stats(clear_stats), .start(start), .missed(missed), .trig_count(trig_count)
  );
  always #5 clk = ~clk;
  // Reference model: a channel is busy while the cycle number is within its holdoff window after its last fire
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      foreach (m_tbl[a]) m_tbl[a] = '0;
      m_v = 0; m_code = '0; m_row = '0;
      e_start = '0; e_missed = '0; e_rdata = '0; e_cnt = '0;
      for (int i = 0; i < NP; i++) begin m_last[i] = -1000000; m_hold[i] = '0; end
    end else begin
      logic [NP-1:0] hit, busy, fire;
      hit = (m_v && m_code != 8'h00 && enable) ? m_row : '0;
      for (int i = 0; i < NP; i++) busy[i] = m_cyc <= m_last[i] + longint'(m_hold[i]);
      fire = hit & ~busy;
      for (int i = 0; i < NP; i++) if (fire[i]) begin m_last[i] = m_cyc; m_hold[i] = holdoff[i*HW +: HW]; end
      e_cnt = clear_stats ? 32'(e_start != 0) : (e_start != 0 && e_cnt != 32'hFFFFFFFF) ? e_cnt + 1 : e_cnt;
      e_missed = (clear_stats ? '0 : e_missed) | (hit & busy);
      e_start = fire;
      e_rdata = m_tbl[bus.cfg_addr];
      m_v = bus.event_valid; m_code = bus.event_code; m_row = m_tbl[bus.event_code];
      if (bus.cfg_we) m_tbl[bus.cfg_addr] = bus.cfg_wdata;
      if (do_preset) begin e_cnt = 32'hFFFFFFFE; force dut.trig_count = 32'hFFFFFFFE; end
      m_cyc++;
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) if (run) begin
    check("start", 32'(start), 32'(e_start));
    check("missed", 32'(missed), 32'(e_missed));
    check("trig_count", trig_count, e_cnt);
    check("cfg_rdata", 32'(bus.cfg_rdata), 32'(e_rdata));
  end
  task automatic tick();
    @(posedge clk); #1;
    bus.event_valid = 0; bus.cfg_we = 0; clear_stats = 0;
  endtask
  task automatic ev(input logic [7:0] c);
    bus.event_code = c; bus.event_valid = 1;
  endtask
  task automatic wr(input logic [7:0] a, input logic [NP-1:0] d);
    bus.cfg_we = 1; bus.cfg_addr = a; bus.cfg_wdata = d; tick();
  endtask
  initial begin
    bus.event_code = '0; bus.event_valid = 0; bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    #2 reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1; enable = 1; run = 1;
    check("reset_start", 32'(start), 32'h0);
    check("reset_cnt", trig_count, 32'h0);
    wr(8'h20, 4'b0101);
    ev(8'h20); tick(); check("t1_early", 32'(start), 32'h0);
    tick(); check("t1_start", 32'(start), 32'h5);
    tick(); check("t1_single", 32'(start), 32'h0); check("t1_cnt", trig_count, 32'd1);
    wr(8'h00, 4'hF);
    ev(8'h00); tick(); check("t2_null", 32'(start), 32'h0);
    ev(8'h33); tick(); check("t2_null2", 32'(start), 32'h0);
    repeat (3) begin tick(); check("t2_start", 32'(start), 32'h0); end
    check("t2_cnt", trig_count, 32'd1);
    clear_stats = 1; holdoff[0 +: HW] = 16'd3; wr(8'h10, 4'b0001);
    s = '0;
    for (int k = 0; k < 14; k++) begin
      if (k <= 10) ev(8'h10);
      tick();
      s[k+1] = start[0];
    end
    check("t3_starts", 32'(s), 32'h444);
    check("t3_missed", 32'(missed), 32'h1);
    check("t3_cnt", trig_count, 32'd3);
    holdoff[0 +: HW] = 16'd0;
    wr(8'h40, 4'b0000);
    bus.cfg_we = 1; bus.cfg_addr = 8'h40; bus.cfg_wdata = 4'b1000; ev(8'h40); tick();
    ev(8'h40); tick(); check("t4_old_entry", 32'(start), 32'h0);
    tick(); check("t4_new_entry", 32'(start), 32'h8);
    repeat (3) tick();
    do_preset = 1; tick(); release dut.trig_count; do_preset = 0;
    check("t5_preset", trig_count, 32'hFFFFFFFE);
    repeat (3) begin ev(8'h20); tick(); end
    repeat (3) tick();
    check("t5_saturate", trig_count, 32'hFFFFFFFF);
    ev(8'h20); tick(); tick(); clear_stats = 1;
    check("t5_fire", 32'(start), 32'h5);
    tick();
    check("t5_clear_cnt", trig_count, 32'd1);
    check("t5_clear_missed", 32'(missed), 32'h0);
    ev(8'h20); tick(); reset = 0;
    tick(); check("t6_abort", 32'(start), 32'h0);
    reset = 1;
    tick(); check("t6_after1", 32'(start), 32'h0);
    tick(); check("t6_after2", 32'(start), 32'h0);
    for (int a = 0; a < 256; a++) begin
      bus.cfg_addr = 8'(a); tick();
      check("t6_rdata", 32'(bus.cfg_rdata), 32'h0);
    end
    for (int n = 0; n < 3000; n++) begin
      bus.cfg_addr = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin bus.cfg_we = 1; bus.cfg_wdata = 4'($urandom); end
      if ($urandom_range(0, 2) != 0) ev(8'($urandom_range(0, 7)));
      enable = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 19) == 0) begin
        int ch;
        ch = int'($urandom_range(0, NP-1));
        holdoff[ch*HW +: HW] = HW'($urandom_range(0, 6));
      end
      clear_stats = $urandom_range(0, 29) == 0;
      if ($urandom_range(0, 499) == 0) begin reset = 0; #1 reset = 1; end
      tick();
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
